i2c_cmd_arbiter: RTL and testbench

Shares the single I2C request-manager command interface between NUM_REQ independent requesters, such as the sensor-config sequencer and the frame-readout engine. Arbitration is round-robin at transaction granularity. A grant covers one command plus all of its write or read data bytes, and is held until the final data byte handshakes, so byte streams never interleave. The block sits between the requester command/byte FIFOs and the request manager's CMD, WR-byte and RD-byte ports.

---
 rtl/i2c_cmd_arbiter_if.sv | 54 +++++
 rtl/i2c_cmd_arbiter.sv | 168 ++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_arbiter_if.sv
// rtl/i2c_cmd_arbiter_if.sv - requester, manager and status signals of the I2C command arbiter
// slave modport is the arbiter's view; master is the view of whatever drives requesters and manager.
interface i2c_cmd_arbiter_if #(
   parameter int NUM_REQ     = 2,
   parameter int BURST_WIDTH = 4
);
   logic [NUM_REQ-1:0]                  i_req_valid;
   logic [NUM_REQ-1:0]                  i_req_we;
   logic [NUM_REQ-1:0]                  i_req_sccb_mode;
   logic [NUM_REQ-1:0][6:0]             i_req_addr_slave;
   logic [NUM_REQ-1:0][7:0]             i_req_addr_reg;
   logic [NUM_REQ-1:0][BURST_WIDTH-1:0] i_req_burst_num;
   logic [NUM_REQ-1:0]                  o_req_ready;
   logic [NUM_REQ-1:0]                  i_req_wr_valid;
   logic [NUM_REQ-1:0][7:0]             i_req_wr_byte;
   logic [NUM_REQ-1:0]                  o_req_wr_ready;
   logic [NUM_REQ-1:0]                  o_req_rd_valid;
   logic [7:0]                          o_req_rd_byte;
   logic [NUM_REQ-1:0]                  i_req_rd_ready;
   logic                                o_valid;
   logic                                o_we;
   logic                                o_sccb_mode;
   logic [6:0]                          o_addr_slave;
   logic [7:0]                          o_addr_reg;
   logic [BURST_WIDTH-1:0]              o_burst_num;
   logic                                i_ready;
   logic                                o_valid_wr_byte;
   logic [7:0]                          o_wr_byte;
   logic                                i_ready_wr_byte;
   logic                                i_rd_valid;
   logic [7:0]                          i_rd_byte;
   logic                                o_ready_rd_byte;
   logic [NUM_REQ-1:0]                  o_grant;
   logic                                o_busy;
   logic                                o_timeout;

   modport slave (
      input  i_req_valid, i_req_we, i_req_sccb_mode, i_req_addr_slave, i_req_addr_reg,
             i_req_burst_num, i_req_wr_valid, i_req_wr_byte, i_req_rd_ready,
             i_ready, i_ready_wr_byte, i_rd_valid, i_rd_byte,
      output o_req_ready, o_req_wr_ready, o_req_rd_valid, o_req_rd_byte,
             o_valid, o_we, o_sccb_mode, o_addr_slave, o_addr_reg, o_burst_num,
             o_valid_wr_byte, o_wr_byte, o_ready_rd_byte, o_grant, o_busy, o_timeout
   );

   modport master (
      output i_req_valid, i_req_we, i_req_sccb_mode, i_req_addr_slave, i_req_addr_reg,
             i_req_burst_num, i_req_wr_valid, i_req_wr_byte, i_req_rd_ready,
             i_ready, i_ready_wr_byte, i_rd_valid, i_rd_byte,
      input  o_req_ready, o_req_wr_ready, o_req_rd_valid, o_req_rd_byte,
             o_valid, o_we, o_sccb_mode, o_addr_slave, o_addr_reg, o_burst_num,
             o_valid_wr_byte, o_wr_byte, o_ready_rd_byte, o_grant, o_busy, o_timeout
   );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - round-robin, transaction-granular arbiter in front of the I2C request manager
// Optional DATA stall abort is built when I2C_ARB_TIMEOUT_EN is defined.
module i2c_cmd_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int BURST_WIDTH    = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input logic              i_clk,
   input logic              i_rst,
   i2c_cmd_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [BURST_WIDTH:0] CNT_ONE = (BURST_WIDTH+1)'(1);

   typedef enum logic [1:0] {IDLE, CMD, DATA, RELEASE} state_t;

   state_t                 state, state_nxt;
   logic [NUM_REQ-1:0]     grant, grant_nxt;
   logic [IDX_W-1:0]       gidx, gidx_nxt;
   logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
   logic [BURST_WIDTH:0]   count, count_nxt;
   logic                   we_q, we_nxt;
   logic                   sccb_q, sccb_nxt;
   logic                   found;
   logic [IDX_W-1:0]       pick;
   logic                   data_hs;
   logic                   timeout;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = 32'(rr_ptr) + 32'(i);
         if (idx >= 32'(NUM_REQ)) idx = idx - 32'(NUM_REQ);
         if (!found && bus.i_req_valid[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
   end

   assign data_hs = (state == DATA) &&
                    (we_q ? (bus.i_req_wr_valid[gidx] && bus.i_ready_wr_byte)
                          : (bus.i_rd_valid && bus.i_req_rd_ready[gidx]));

`ifdef I2C_ARB_TIMEOUT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || state != DATA || data_hs) stall_cnt <= '0;
      else                                   stall_cnt <= stall_cnt + 32'd1;
   end

   // Fires in the TIMEOUT_CYCLES-th consecutive DATA cycle without a byte handshake.
   assign timeout = (state == DATA) && !data_hs && (stall_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= IDLE;
         grant  <= '0;
         gidx   <= '0;
         rr_ptr <= '0;
         count  <= '0;
         we_q   <= 1'b0;
         sccb_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         gidx   <= gidx_nxt;
         rr_ptr <= rr_ptr_nxt;
         count  <= count_nxt;
         we_q   <= we_nxt;
         sccb_q <= sccb_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      gidx_nxt   = gidx;
      rr_ptr_nxt = rr_ptr;
      count_nxt  = count;
      we_nxt     = we_q;
      sccb_nxt   = sccb_q;
      case (state)
         IDLE: begin
            if (found) begin
               grant_nxt = NUM_REQ'(1) << pick;
               gidx_nxt  = pick;
               state_nxt = CMD;
            end
         end
         CMD: begin
            if (bus.i_req_valid[gidx] && bus.i_ready) begin
               we_nxt    = bus.i_req_we[gidx];
               sccb_nxt  = bus.i_req_sccb_mode[gidx];
               // SCCB transactions always carry exactly one data byte.
               count_nxt = bus.i_req_sccb_mode[gidx] ? CNT_ONE
                                                     : {1'b0, bus.i_req_burst_num[gidx]} + CNT_ONE;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (timeout) begin
               state_nxt = RELEASE;
            end else if (data_hs) begin
               count_nxt = count - CNT_ONE;
               if (count == CNT_ONE) state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            rr_ptr_nxt = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
            grant_nxt  = '0;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.o_req_ready     = '0;
      bus.o_req_wr_ready  = '0;
      bus.o_req_rd_valid  = '0;
      bus.o_req_rd_byte   = '0;
      bus.o_valid         = 1'b0;
      bus.o_we            = 1'b0;
      bus.o_sccb_mode     = 1'b0;
      bus.o_addr_slave    = '0;
      bus.o_addr_reg      = '0;
      bus.o_burst_num     = '0;
      bus.o_valid_wr_byte = 1'b0;
      bus.o_wr_byte       = '0;
      bus.o_ready_rd_byte = 1'b0;
      case (state)
         CMD: begin
            bus.o_valid           = bus.i_req_valid[gidx];
            bus.o_we              = bus.i_req_we[gidx];
            bus.o_sccb_mode       = bus.i_req_sccb_mode[gidx];
            bus.o_addr_slave      = bus.i_req_addr_slave[gidx];
            bus.o_addr_reg        = bus.i_req_addr_reg[gidx];
            bus.o_burst_num       = bus.i_req_burst_num[gidx];
            bus.o_req_ready[gidx] = bus.i_ready;
         end
         DATA: begin
            if (we_q) begin
               bus.o_valid_wr_byte      = bus.i_req_wr_valid[gidx];
               bus.o_wr_byte            = bus.i_req_wr_byte[gidx];
               bus.o_req_wr_ready[gidx] = bus.i_ready_wr_byte;
            end else begin
               bus.o_req_rd_valid[gidx] = bus.i_rd_valid;
               bus.o_req_rd_byte        = bus.i_rd_byte;
               bus.o_ready_rd_byte      = bus.i_req_rd_ready[gidx];
            end
         end
         default: ;
      endcase
   end

   assign bus.o_grant   = grant;
   assign bus.o_busy    = (state != IDLE);
   assign bus.o_timeout = timeout;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb/tb_i2c_cmd_arbiter.sv - directed self-checking bench for i2c_cmd_arbiter
module tb_i2c_cmd_arbiter;
   localparam int NR = 2;
   localparam int BW = 4;

   logic i_clk = 1'b0;
   logic i_rst;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [NR-1:0] rr_seq [4];
   int            rr_n;
   logic [NR-1:0] rr_prev;

   i2c_cmd_arbiter_if #(.NUM_REQ(NR), .BURST_WIDTH(BW)) bus ();

   i2c_cmd_arbiter #(.NUM_REQ(NR), .BURST_WIDTH(BW), .TIMEOUT_CYCLES(16)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.i_req_valid      = '0;
      bus.i_req_we         = '0;
      bus.i_req_sccb_mode  = '0;
      bus.i_req_addr_slave = '0;
      bus.i_req_addr_reg   = '0;
      bus.i_req_burst_num  = '0;
      bus.i_req_wr_valid   = '0;
      bus.i_req_wr_byte    = '0;
      bus.i_req_rd_ready   = '0;
      bus.i_ready          = 1'b0;
      bus.i_ready_wr_byte  = 1'b0;
      bus.i_rd_valid       = 1'b0;
      bus.i_rd_byte        = '0;
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic wait_grant(input string tag, input logic [NR-1:0] exp);
      int n;
      n = 0;
      while (bus.o_grant !== exp && n < 20) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      check(tag, bus.o_grant, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1;
      clear_inputs();
      do_reset();
      #1;
      check("rst_grant", bus.o_grant, 0);
      check("rst_busy", bus.o_busy, 0);
      check("rst_valid", bus.o_valid, 0);
      check("rst_req_ready", bus.o_req_ready, 0);
      check("rst_timeout", bus.o_timeout, 0);
      bus.i_rd_valid = 1'b1; bus.i_rd_byte = 8'h99; bus.i_req_rd_ready = 2'b11;
      #1;
      check("idle_rd_ready", bus.o_ready_rd_byte, 0);
      check("idle_rd_valid", bus.o_req_rd_valid, 0);
      clear_inputs();

      // single write from req0
      bus.i_req_valid[0] = 1'b1; bus.i_req_we[0] = 1'b1;
      bus.i_req_addr_slave[0] = 7'h33; bus.i_req_addr_reg[0] = 8'h24; bus.i_req_burst_num[0] = 4'd2;
      #1;
      check("wr_idle_no_fwd", bus.o_valid, 0);
      @(negedge i_clk); #1;
      check("wr_grant", bus.o_grant, 2'b01);
      check("wr_o_valid", bus.o_valid, 1);
      check("wr_addr_slave", bus.o_addr_slave, 8'h33);
      check("wr_addr_reg", bus.o_addr_reg, 8'h24);
      check("wr_burst", bus.o_burst_num, 2);
      check("wr_we", bus.o_we, 1);
      bus.i_ready = 1'b1;
      #1;
      check("wr_req_ready", bus.o_req_ready, 2'b01);
      @(negedge i_clk);
      bus.i_req_valid = '0; bus.i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.i_req_wr_valid[0] = 1'b1; bus.i_req_wr_byte[0] = 8'hA1 + 8'(k); bus.i_ready_wr_byte = 1'b1;
         #1;
         check("wr_byte_valid", bus.o_valid_wr_byte, 1);
         check("wr_byte", bus.o_wr_byte, 8'hA1 + k);
         check("wr_pop", bus.o_req_wr_ready, 2'b01);
         @(negedge i_clk);
      end
      bus.i_req_wr_byte[0] = 8'hA4;
      #1;
      check("wr_release_pop", bus.o_req_wr_ready, 0);
      check("wr_release_busy", bus.o_busy, 1);
      clear_inputs();
      @(negedge i_clk); #1;
      check("wr_idle_busy", bus.o_busy, 0);
      check("wr_idle_grant", bus.o_grant, 0);

      // round robin: both requesters continuously issue one-byte writes
      do_reset();
      bus.i_req_valid = 2'b11; bus.i_req_we = 2'b11; bus.i_ready = 1'b1;
      bus.i_req_wr_valid = 2'b11; bus.i_ready_wr_byte = 1'b1;
      rr_n = 0; rr_prev = '0;
      for (int c = 0; c < 16; c++) begin
         @(negedge i_clk); #1;
         check("rr_onehot", ($countones(bus.o_grant) > 1), 0);
         if (bus.o_grant != 0 && bus.o_grant != rr_prev && rr_n < 4) begin
            rr_seq[rr_n] = bus.o_grant;
            rr_n++;
         end
         rr_prev = bus.o_grant;
      end
      clear_inputs();
      check("rr_count", rr_n, 4);
      check("rr_g0", rr_seq[0], 2'b01);
      check("rr_g1", rr_seq[1], 2'b10);
      check("rr_g2", rr_seq[2], 2'b01);
      check("rr_g3", rr_seq[3], 2'b10);
      @(negedge i_clk); #1;
      check("rr_idle", bus.o_busy, 0);

      // read routed to req1 only
      bus.i_req_valid[1] = 1'b1; bus.i_req_burst_num[1] = 4'd1; bus.i_ready = 1'b1;
      bus.i_req_rd_ready = 2'b11;
      wait_grant("rd_grant", 2'b10);
      check("rd_we", bus.o_we, 0);
      check("rd_burst", bus.o_burst_num, 1);
      check("rd_req_ready", bus.o_req_ready, 2'b10);
      @(negedge i_clk);
      bus.i_req_valid = '0; bus.i_ready = 1'b0;
      bus.i_rd_valid = 1'b1; bus.i_rd_byte = 8'h5A;
      #1;
      check("rd_valid_a", bus.o_req_rd_valid, 2'b10);
      check("rd_byte_a", bus.o_req_rd_byte, 8'h5A);
      check("rd_mgr_ready_a", bus.o_ready_rd_byte, 1);
      @(negedge i_clk);
      bus.i_rd_byte = 8'hC3;
      #1;
      check("rd_valid_b", bus.o_req_rd_valid, 2'b10);
      check("rd_byte_b", bus.o_req_rd_byte, 8'hC3);
      @(negedge i_clk);
      bus.i_rd_byte = 8'h77;
      #1;
      check("rd_release_valid", bus.o_req_rd_valid, 0);
      check("rd_release_ready", bus.o_ready_rd_byte, 0);
      clear_inputs();
      @(negedge i_clk); #1;
      check("rd_idle", bus.o_busy, 0);

      // SCCB write with a mid-command valid drop; only one byte is taken
      bus.i_req_valid[0] = 1'b1; bus.i_req_we[0] = 1'b1; bus.i_req_sccb_mode[0] = 1'b1;
      bus.i_req_burst_num[0] = 4'd7;
      wait_grant("sccb_grant", 2'b01);
      bus.i_req_valid[0] = 1'b0; bus.i_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("sccb_hold_grant", bus.o_grant, 2'b01);
         check("sccb_hold_valid", bus.o_valid, 0);
         @(negedge i_clk);
      end
      bus.i_req_valid[0] = 1'b1;
      #1;
      check("sccb_mode", bus.o_sccb_mode, 1);
      check("sccb_burst", bus.o_burst_num, 7);
      check("sccb_valid", bus.o_valid, 1);
      @(negedge i_clk);
      bus.i_req_valid = '0; bus.i_ready = 1'b0;
      bus.i_req_wr_valid[0] = 1'b1; bus.i_req_wr_byte[0] = 8'hBB; bus.i_ready_wr_byte = 1'b1;
      #1;
      check("sccb_byte", bus.o_wr_byte, 8'hBB);
      check("sccb_pop", bus.o_req_wr_ready, 2'b01);
      @(negedge i_clk);
      bus.i_req_wr_byte[0] = 8'hBC;
      #1;
      check("sccb_one_byte", bus.o_req_wr_ready, 0);
      check("sccb_release_busy", bus.o_busy, 1);
      clear_inputs();
      @(negedge i_clk); #1;
      check("sccb_idle", bus.o_busy, 0);

      // read backpressure on req0
      bus.i_req_valid[0] = 1'b1; bus.i_req_burst_num[0] = 4'd1; bus.i_ready = 1'b1;
      wait_grant("bp_grant", 2'b01);
      @(negedge i_clk);
      bus.i_req_valid = '0; bus.i_ready = 1'b0;
      bus.i_rd_valid = 1'b1; bus.i_rd_byte = 8'hE7; bus.i_req_rd_ready[0] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         check("bp_stall_ready", bus.o_ready_rd_byte, 0);
         check("bp_stall_valid", bus.o_req_rd_valid, 2'b01);
         @(negedge i_clk);
      end
      bus.i_req_rd_ready[0] = 1'b1;
      #1;
      check("bp_ready", bus.o_ready_rd_byte, 1);
      check("bp_byte_a", bus.o_req_rd_byte, 8'hE7);
      @(negedge i_clk);
      bus.i_rd_byte = 8'h3C;
      #1;
      check("bp_second_valid", bus.o_req_rd_valid, 2'b01);
      check("bp_byte_b", bus.o_req_rd_byte, 8'h3C);
      @(negedge i_clk); #1;
      check("bp_release", bus.o_req_rd_valid, 0);
      clear_inputs();
      @(negedge i_clk); #1;
      check("bp_idle", bus.o_busy, 0);

      // stalled write on req1 while req0 waits
      bus.i_req_valid = 2'b11; bus.i_req_we = 2'b11; bus.i_ready = 1'b1;
      wait_grant("to_grant", 2'b10);
      @(negedge i_clk);
      bus.i_ready = 1'b0; bus.i_ready_wr_byte = 1'b1;
      for (int d = 1; d <= 16; d++) begin
         #1;
`ifdef I2C_ARB_TIMEOUT_EN
         check("to_pulse", bus.o_timeout, (d == 16));
`else
         check("to_quiet", bus.o_timeout, 0);
`endif
         @(negedge i_clk);
      end
      #1;
`ifdef I2C_ARB_TIMEOUT_EN
      check("to_pulse_end", bus.o_timeout, 0);
      check("to_release_grant", bus.o_grant, 2'b10);
`else
      repeat (20) @(negedge i_clk);
      #1;
      check("to_wait_busy", bus.o_busy, 1);
      check("to_wait_grant", bus.o_grant, 2'b10);
      check("to_wait_quiet", bus.o_timeout, 0);
      bus.i_req_wr_valid[1] = 1'b1; bus.i_req_wr_byte[1] = 8'h55;
      @(negedge i_clk);
      bus.i_req_wr_valid = '0;
`endif
      wait_grant("to_next_grant", 2'b01);

      do_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
